// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the two-entry pipeline skid stage.
//               Holds the occupancy width and the control-state encoding.
//               The state value is the number of held entries, so occupancy
//               can be driven straight from the state register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int c_OCC_W = 2;

   typedef enum logic [c_OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : WIDTH-bit payload register with synchronous reset value,
//               load enable and synchronous clear (clear loads RST_VAL).
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (q <= RST_VAL)
//               clr  - synchronous clear, priority over load (q <= RST_VAL)
//               load - capture d
//               d    - data in
//               q    - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
   parameter int               WIDTH   = 170,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q <= RST_VAL;
      end else if (load) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Two-entry valid/ready pipeline stage with a skid register.
//               in_ready is registered, so upstream never sees a
//               combinational path from out_ready. out_data is driven
//               directly from the main register. Includes a saturating
//               counter of back-pressured cycles.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               flush            - drop all held entries
//               in_valid/in_ready/in_data    - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
//               occupancy        - entries held (0..2)
//               stall_cnt        - cycles with out_valid & !out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int               WIDTH    = 170,
   parameter int               CNT_W    = 16,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [c_OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_accept;
   logic             w_pop;
   logic             w_main_load;
   logic             w_skid_load;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   assign w_accept = in_valid & r_in_ready;
   assign w_pop    = out_valid & out_ready;

   // ---------------------------------------------------------------------
   // Next-state and payload-load decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      w_main_d    = in_data;

      unique case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ONE;
               w_main_load = 1'b1;
            end
         end
         ONE: begin
            if (w_accept && w_pop) begin
               w_main_load = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = TWO;
               w_skid_load = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only a pop can move the state.
            if (w_pop) begin
               w_state_nxt = ONE;
               w_main_load = 1'b1;
               w_main_d    = w_skid_q;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase

      // Flush wins over everything; the registers clear themselves via clr.
      if (flush) begin
         w_state_nxt = EMPTY;
         w_main_load = 1'b0;
         w_skid_load = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // State register and registered in_ready (low only when full next cycle)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != TWO);
      end
   end

   // Back-pressure counter: saturates, ignores flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   pipe_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_DATA)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .load (w_main_load),
      .d    (w_main_d),
      .q    (w_main_q)
   );

   pipe_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_DATA)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .load (w_skid_load),
      .d    (in_data),
      .q    (w_skid_q)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != EMPTY);
   assign out_data  = w_main_q;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule : pipe_skid_stage
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Directed, table-driven bench for pipe_skid_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

   localparam int          WIDTH = 16;
   localparam int          CNT_W = 3;
   localparam logic [15:0] RSTD  = 16'hDEAD;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(
      .WIDTH    (WIDTH),
      .CNT_W    (CNT_W),
      .RST_DATA (RSTD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [15:0] e_od;
      logic [1:0]  e_occ;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Apply inputs, clock one edge, sample 1 time unit later.
   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [15:0] id, input logic ordy);
      rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic r, logic f, logic iv, logic [15:0] id, logic ordy,
                               logic ir, logic ov, logic [15:0] od, logic [1:0] occ);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_occ = occ;
      return v;
   endfunction

   initial begin
      // ---- vector table: inputs for one edge, expected outputs after it ----
      // reset while offering data
      vecs.push_back(mk(1,0,1,16'h0055,0, 1,0,RSTD,0));
      // stream 1..8 with out_ready high: each visible 1 cycle after accept
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(0,0,1,16'(k),1, 1,1,16'(k),1));
      vecs.push_back(mk(0,0,0,16'h0000,1, 1,0,16'h0008,0));
      // back-pressure: A in, B into skid, C held upstream, then drain
      vecs.push_back(mk(0,0,1,16'h000A,0, 1,1,16'h000A,1));
      vecs.push_back(mk(0,0,1,16'h000B,0, 0,1,16'h000A,2));
      vecs.push_back(mk(0,0,1,16'h000C,0, 0,1,16'h000A,2));
      vecs.push_back(mk(0,0,1,16'h000C,1, 1,1,16'h000B,1));
      vecs.push_back(mk(0,0,1,16'h000C,1, 1,1,16'h000C,1));
      vecs.push_back(mk(0,0,0,16'h0000,1, 1,0,16'h000C,0));
      // flush while full with D offered: D discarded
      vecs.push_back(mk(0,0,1,16'h000A,0, 1,1,16'h000A,1));
      vecs.push_back(mk(0,0,1,16'h000B,0, 0,1,16'h000A,2));
      vecs.push_back(mk(0,1,1,16'h000D,0, 1,0,RSTD,0));
      vecs.push_back(mk(0,0,0,16'h0000,1, 1,0,RSTD,0));
      vecs.push_back(mk(0,0,1,16'h000E,0, 1,1,16'h000E,1));
      vecs.push_back(mk(0,0,0,16'h0000,1, 1,0,16'h000E,0));
      // flush coinciding with a pop in ONE
      vecs.push_back(mk(0,0,1,16'h0005,0, 1,1,16'h0005,1));
      vecs.push_back(mk(0,1,0,16'h0000,1, 1,0,RSTD,0));
      // reset while full with input offered, then first accept after release
      vecs.push_back(mk(0,0,1,16'h000A,0, 1,1,16'h000A,1));
      vecs.push_back(mk(0,0,1,16'h000B,0, 0,1,16'h000A,2));
      vecs.push_back(mk(1,0,1,16'h000F,1, 1,0,RSTD,0));
      vecs.push_back(mk(0,0,1,16'h0007,0, 1,1,16'h0007,1));
      vecs.push_back(mk(0,0,0,16'h0000,1, 1,0,16'h0007,0));

      #2;
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         chk("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_ir));
         chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
         chk("out_data",  i, 32'(out_data),  32'(vecs[i].e_od));
         chk("occupancy", i, 32'(occupancy), 32'(vecs[i].e_occ));
      end

      // ---- stall counter saturation and flush immunity (CNT_W = 3) ----
      step(1, 0, 0, 16'h0000, 0);
      chk("stall_rst", 0, 32'(stall_cnt), 32'd0);
      step(0, 0, 1, 16'h0001, 0);
      chk("stall_first", 0, 32'(stall_cnt), 32'd0);
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 0, 16'h0000, 0);
         chk("stall_cnt", k, 32'(stall_cnt), (k + 1 < 7) ? 32'(k + 1) : 32'd7);
      end
      step(0, 1, 0, 16'h0000, 0);
      chk("stall_flush", 0, 32'(stall_cnt), 32'd7);
      chk("flush_occ", 0, 32'(occupancy), 32'd0);
      step(0, 0, 0, 16'h0000, 0);
      chk("stall_hold", 0, 32'(stall_cnt), 32'd7);
      // counter must not move while downstream is ready
      step(1, 0, 0, 16'h0000, 0);
      step(0, 0, 1, 16'h0003, 1);
      step(0, 0, 0, 16'h0000, 1);
      chk("stall_noinc", 0, 32'(stall_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pipe_skid_stage
`default_nettype wire
